// File: rtl/calc_entry_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_entry_debounce / calc_entry_sequencer
//  Description : Calculator entry front-end. Synchronizes and debounces the
//                buttons, decodes the rotary encoder, and sequences operand /
//                operator entry, the compute handshake and result display.
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Button conditioner: 2-flop synchronizer, stable-level debounce and a
// one-cycle pulse on the rising edge of the debounced level.
// ----------------------------------------------------------------------------
module calc_entry_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_o
);

    localparam logic [15:0] C_DEB_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic [1:0]  sync_q;
    logic        level_q;
    logic        level_prev_q;
    logic [15:0] cnt_q;

    // Synchronize, then accept a new level only after it has held for the full window
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= 2'b00;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= 16'd0;
        end else begin
            sync_q       <= {sync_q[0], raw_i};
            level_prev_q <= level_q;
            if (sync_q[1] != level_q) begin
                if (cnt_q == C_DEB_LAST) begin
                    level_q <= sync_q[1];
                    cnt_q   <= 16'd0;
                end else begin
                    cnt_q   <= cnt_q + 16'd1;
                end
            end else begin
                // Any return to the accepted level restarts the window
                cnt_q <= 16'd0;
            end
        end
    end

    assign press_o = level_q & ~level_prev_q;

endmodule

// ----------------------------------------------------------------------------
// Top level entry sequencer
// ----------------------------------------------------------------------------
module calc_entry_sequencer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter logic [15:0] TIMEOUT_CYCLES  = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select,
    input  logic        restart,
    input  logic        rotary_a,
    input  logic        rotary_b,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic [1:0]  opcode,
    output logic        req_valid,
    input  logic        req_ready,
    input  logic [15:0] result,
    input  logic        result_valid,
    output logic [15:0] disp_value,
    output logic [2:0]  disp_mode,
    output logic        led_flag
);

    localparam logic [15:0] C_TO_LAST = TIMEOUT_CYCLES - 16'd1;

    typedef enum logic [2:0] {
        ST_ENTER_A     = 3'd0,
        ST_ENTER_OP    = 3'd1,
        ST_ENTER_B     = 3'd2,
        ST_REQUEST     = 3'd3,
        ST_WAIT_RESULT = 3'd4,
        ST_SHOW        = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic [1:0]  opcode_q, opcode_d;
    logic [15:0] result_q, result_d;
    logic        err_q, err_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        req_valid_q, req_valid_d;
    logic [15:0] disp_value_q, disp_value_d;

    logic [1:0]  rot_a_sync_q;
    logic [1:0]  rot_b_sync_q;
    logic        rot_a_prev_q;

    logic        sel_evt;
    logic        rst_evt;
    logic        step_evt;
    logic [7:0]  step_delta;

    calc_entry_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_select (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (select),
        .press_o (sel_evt)
    );

    calc_entry_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_restart (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (restart),
        .press_o (rst_evt)
    );

    // Rotary phases are synchronized but not debounced; a step fires on the A rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_a_sync_q <= 2'b00;
            rot_b_sync_q <= 2'b00;
            rot_a_prev_q <= 1'b0;
        end else begin
            rot_a_sync_q <= {rot_a_sync_q[0], rotary_a};
            rot_b_sync_q <= {rot_b_sync_q[0], rotary_b};
            rot_a_prev_q <= rot_a_sync_q[1];
        end
    end

    assign step_evt   = rot_a_sync_q[1] & ~rot_a_prev_q;
    // B low means clockwise (+1); otherwise -1 expressed as modular add of 8'hFF
    assign step_delta = rot_b_sync_q[1] ? 8'hFF : 8'h01;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ENTER_A;
            op_a_q       <= 8'd0;
            op_b_q       <= 8'd0;
            opcode_q     <= 2'd0;
            result_q     <= 16'd0;
            err_q        <= 1'b0;
            to_cnt_q     <= 16'd0;
            req_valid_q  <= 1'b0;
            disp_value_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            opcode_q     <= opcode_d;
            result_q     <= result_d;
            err_q        <= err_d;
            to_cnt_q     <= to_cnt_d;
            req_valid_q  <= req_valid_d;
            disp_value_q <= disp_value_d;
        end
    end

    // Next-state, field editing, handshake and display selection
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        opcode_d     = opcode_q;
        result_d     = result_q;
        err_d        = err_q;
        to_cnt_d     = to_cnt_q;
        req_valid_d  = 1'b0;
        disp_value_d = 16'd0;

        if (rst_evt) begin
            // Restart dominates every other event in the same cycle
            state_d  = ST_ENTER_A;
            op_a_d   = 8'd0;
            op_b_d   = 8'd0;
            opcode_d = 2'd0;
            result_d = 16'd0;
            err_d    = 1'b0;
            to_cnt_d = 16'd0;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (step_evt) op_a_d = op_a_q + step_delta;
                    if (sel_evt)  state_d = ST_ENTER_OP;
                end
                ST_ENTER_OP: begin
                    if (step_evt) opcode_d = opcode_q + step_delta[1:0];
                    if (sel_evt)  state_d = ST_ENTER_B;
                end
                ST_ENTER_B: begin
                    if (step_evt) op_b_d = op_b_q + step_delta;
                    if (sel_evt)  state_d = ST_REQUEST;
                end
                ST_REQUEST: begin
                    if (req_valid_q && req_ready) begin
                        state_d  = ST_WAIT_RESULT;
                        to_cnt_d = 16'd0;
                    end
                end
                ST_WAIT_RESULT: begin
                    if (result_valid) begin
                        result_d = result;
                        err_d    = 1'b0;
                        state_d  = ST_SHOW;
                    end else if (to_cnt_q == C_TO_LAST) begin
                        result_d = 16'hFFFF;
                        err_d    = 1'b1;
                        state_d  = ST_SHOW;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
                ST_SHOW: begin
                    if (sel_evt) state_d = ST_ENTER_A;
                end
                default: state_d = ST_ENTER_A;
            endcase
        end

        // Outputs are derived from next-state values so the registered copies
        // line up with the state they describe
        req_valid_d = (state_d == ST_REQUEST);
        case (state_d)
            ST_ENTER_A:     disp_value_d = {8'h00, op_a_d};
            ST_ENTER_OP:    disp_value_d = {14'h0000, opcode_d};
            ST_ENTER_B,
            ST_REQUEST,
            ST_WAIT_RESULT: disp_value_d = {8'h00, op_b_d};
            ST_SHOW:        disp_value_d = result_d;
            default:        disp_value_d = 16'd0;
        endcase
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign opcode     = opcode_q;
    assign req_valid  = req_valid_q;
    assign disp_value = disp_value_q;
    assign disp_mode  = state_q;
    assign led_flag   = err_q;

endmodule
`default_nettype wire
